// File: rtl/tl_ram_pkg.sv
// rtl/tl_ram_pkg.sv - TileLink-UL opcodes, widths and A/D channel beat types
package tl_ram_pkg;

  localparam int SRC_W  = 8;
  localparam int ADDR_W = 31;
  localparam int DATA_W = 64;
  localparam int MASK_W = 8;
  localparam int SIZE_W = 4;

  localparam logic [2:0] PUT_FULL    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] GET         = 3'd4;

  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  typedef struct packed {
    logic [2:0]        opcode;
    logic [2:0]        param;
    logic [SIZE_W-1:0] size;
    logic [SRC_W-1:0]  source;
    logic [ADDR_W-1:0] address;
    logic [MASK_W-1:0] mask;
    logic [DATA_W-1:0] data;
    logic              corrupt;
  } tl_a_t;

  typedef struct packed {
    logic [2:0]        opcode;
    logic [1:0]        param;
    logic [SIZE_W-1:0] size;
    logic [SRC_W-1:0]  source;
    logic              denied;
    logic [DATA_W-1:0] data;
    logic              corrupt;
  } tl_d_t;

  // Single-beat responder only understands Get/PutFull/PutPartial up to one 64-bit word.
  function automatic logic a_legal(input logic [2:0] opcode, input logic [SIZE_W-1:0] size);
    return ((opcode == PUT_FULL) || (opcode == PUT_PARTIAL) || (opcode == GET))
           && (size <= 4'd3);
  endfunction

endpackage

// File: rtl/tl_ram_array.sv
// rtl/tl_ram_array.sv - DEPTH x 64 byte-write SRAM with registered synchronous read
module tl_ram_array
  import tl_ram_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic [MASK_W-1:0] i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];
  logic [DATA_W-1:0] r_rdata;

  // Byte-lane masked write; contents are intentionally never reset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < MASK_W; i++) begin
      if (i_we[i]) begin
        r_mem[i_waddr][i*8 +: 8] <= i_wdata[i*8 +: 8];
      end
    end
  end

  // Read data only updates on an enabled read, so it holds while the response stalls.
  always_ff @(posedge clock) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/tl_ram_responder.sv
// rtl/tl_ram_responder.sv - TileLink-UL single-beat RAM responder (optional TL_RAM_ADDR_CHECK_EN)
module tl_ram_responder
  import tl_ram_pkg::*;
#(
  parameter int          DEPTH = 256,
  parameter logic [30:0] BASE  = 31'h0800_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_a_valid,
  output logic        io_a_ready,
  input  logic [2:0]  io_a_bits_opcode,
  input  logic [2:0]  io_a_bits_param,
  input  logic [3:0]  io_a_bits_size,
  input  logic [7:0]  io_a_bits_source,
  input  logic [30:0] io_a_bits_address,
  input  logic [7:0]  io_a_bits_mask,
  input  logic [63:0] io_a_bits_data,
  input  logic        io_a_bits_corrupt,
  input  logic        io_d_ready,
  output logic        io_d_valid,
  output logic [2:0]  io_d_bits_opcode,
  output logic [1:0]  io_d_bits_param,
  output logic [3:0]  io_d_bits_size,
  output logic [7:0]  io_d_bits_source,
  output logic        io_d_bits_denied,
  output logic [63:0] io_d_bits_data,
  output logic        io_d_bits_corrupt
);

  localparam int AW = $clog2(DEPTH);

  tl_a_t             w_a;
  tl_d_t             w_d;
  logic              w_a_ready;
  logic              w_a_fire;
  logic              w_legal;
  logic              w_in_range;
  logic              w_is_get;
  logic              w_is_put;
  logic [AW-1:0]     w_idx;
  logic [MASK_W-1:0] w_we;
  logic              w_re;
  logic [DATA_W-1:0] w_rdata;
  logic              w_unused;

  logic              r_d_valid;
  logic [2:0]        r_d_opcode;
  logic [SIZE_W-1:0] r_d_size;
  logic [SRC_W-1:0]  r_d_source;
  logic              r_d_denied;
  logic              r_d_corrupt;
  logic              r_d_rdsel;

  assign w_a = '{
    opcode:  io_a_bits_opcode,
    param:   io_a_bits_param,
    size:    io_a_bits_size,
    source:  io_a_bits_source,
    address: io_a_bits_address,
    mask:    io_a_bits_mask,
    data:    io_a_bits_data,
    corrupt: io_a_bits_corrupt
  };

  // The single response register can take a new beat whenever it empties this cycle.
  assign w_a_ready = ~r_d_valid | io_d_ready;
  assign w_a_fire  = io_a_valid & w_a_ready & ~reset;

  assign w_legal  = a_legal(w_a.opcode, w_a.size);
  assign w_is_get = (w_a.opcode == GET);
  assign w_is_put = (w_a.opcode == PUT_FULL) | (w_a.opcode == PUT_PARTIAL);
  assign w_idx    = w_a.address[3+AW-1:3];

`ifdef TL_RAM_ADDR_CHECK_EN
  assign w_in_range = (w_a.address[ADDR_W-1:3+AW] == BASE[ADDR_W-1:3+AW]);
  assign w_unused   = ^{w_a.param, w_a.address[2:0]};
`else
  // No decode of the upper address: every address aliases into the array.
  assign w_in_range = 1'b1;
  assign w_unused   = ^{w_a.param, w_a.address[2:0], w_a.address[ADDR_W-1:3+AW], BASE};
`endif

  // Poisoned write data is acknowledged but never lands in the array.
  assign w_we = {MASK_W{w_a_fire & w_is_put & w_legal & w_in_range & ~w_a.corrupt}} & w_a.mask;
  assign w_re = w_a_fire & w_is_get & w_legal & w_in_range;

  tl_ram_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clock   (clock),
    .i_we    (w_we),
    .i_waddr (w_idx),
    .i_wdata (w_a.data),
    .i_re    (w_re),
    .i_raddr (w_idx),
    .o_rdata (w_rdata)
  );

  // Response register: load on A fire, drain on D fire, hold otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_d_valid   <= 1'b0;
      r_d_opcode  <= '0;
      r_d_size    <= '0;
      r_d_source  <= '0;
      r_d_denied  <= 1'b0;
      r_d_corrupt <= 1'b0;
      r_d_rdsel   <= 1'b0;
    end else if (w_a_fire) begin
      r_d_valid   <= 1'b1;
      r_d_opcode  <= (w_legal & w_is_get) ? ACCESS_ACK_DATA : ACCESS_ACK;
      r_d_size    <= w_a.size;
      r_d_source  <= w_a.source;
      r_d_denied  <= ~w_legal | ~w_in_range;
      r_d_corrupt <= w_legal & w_is_get & ~w_in_range;
      r_d_rdsel   <= w_re;
    end else if (io_d_ready) begin
      r_d_valid   <= 1'b0;
    end
  end

  // Array output is only exposed for a successful Get; everything else returns zero data.
  assign w_d = '{
    opcode:  r_d_opcode,
    param:   2'd0,
    size:    r_d_size,
    source:  r_d_source,
    denied:  r_d_denied,
    data:    r_d_rdsel ? w_rdata : '0,
    corrupt: r_d_corrupt
  };

  assign io_a_ready        = w_a_ready;
  assign io_d_valid        = r_d_valid;
  assign io_d_bits_opcode  = w_d.opcode;
  assign io_d_bits_param   = w_d.param;
  assign io_d_bits_size    = w_d.size;
  assign io_d_bits_source  = w_d.source;
  assign io_d_bits_denied  = w_d.denied;
  assign io_d_bits_data    = w_d.data;
  assign io_d_bits_corrupt = w_d.corrupt;

endmodule

// File: tb/tb_tl_ram_responder.sv
// tb/tb_tl_ram_responder.sv - randomized self-checking bench for tl_ram_responder
module tb_tl_ram_responder;

  localparam logic [30:0] BASE = 31'h0800_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_a_valid;
  logic        io_a_ready;
  logic [2:0]  io_a_bits_opcode;
  logic [2:0]  io_a_bits_param;
  logic [3:0]  io_a_bits_size;
  logic [7:0]  io_a_bits_source;
  logic [30:0] io_a_bits_address;
  logic [7:0]  io_a_bits_mask;
  logic [63:0] io_a_bits_data;
  logic        io_a_bits_corrupt;
  logic        io_d_ready;
  logic        io_d_valid;
  logic [2:0]  io_d_bits_opcode;
  logic [1:0]  io_d_bits_param;
  logic [3:0]  io_d_bits_size;
  logic [7:0]  io_d_bits_source;
  logic        io_d_bits_denied;
  logic [63:0] io_d_bits_data;
  logic        io_d_bits_corrupt;

  always #5 clock = ~clock;

  tl_ram_responder dut (
    .clock             (clock),
    .reset             (reset),
    .io_a_valid        (io_a_valid),
    .io_a_ready        (io_a_ready),
    .io_a_bits_opcode  (io_a_bits_opcode),
    .io_a_bits_param   (io_a_bits_param),
    .io_a_bits_size    (io_a_bits_size),
    .io_a_bits_source  (io_a_bits_source),
    .io_a_bits_address (io_a_bits_address),
    .io_a_bits_mask    (io_a_bits_mask),
    .io_a_bits_data    (io_a_bits_data),
    .io_a_bits_corrupt (io_a_bits_corrupt),
    .io_d_ready        (io_d_ready),
    .io_d_valid        (io_d_valid),
    .io_d_bits_opcode  (io_d_bits_opcode),
    .io_d_bits_param   (io_d_bits_param),
    .io_d_bits_size    (io_d_bits_size),
    .io_d_bits_source  (io_d_bits_source),
    .io_d_bits_denied  (io_d_bits_denied),
    .io_d_bits_data    (io_d_bits_data),
    .io_d_bits_corrupt (io_d_bits_corrupt)
  );

  typedef struct {
    logic [2:0]  opcode;
    logic [3:0]  size;
    logic [7:0]  source;
    logic        denied;
    logic [63:0] data;
    logic        corrupt;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] m_mem [256];
  int          n_cmp = 0;
  int          n_err = 0;
  int          step_no = 0;
  int          dsrc_log[$];
  int          dcyc_log[$];
  logic [2:0]  last_op;
  logic [7:0]  last_src;
  logic        last_den;
  logic        last_cor;
  logic [63:0] last_data;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic addr_in_range(input logic [30:0] addr);
`ifdef TL_RAM_ADDR_CHECK_EN
    return addr[30:11] == BASE[30:11];
`else
    return 1'b1;
`endif
  endfunction

  // Reference model: what the slave must answer, applying the memory effect at accept time.
  task automatic model_accept(input logic [2:0] op, input logic [3:0] sz, input logic [7:0] src,
                              input logic [30:0] addr, input logic [7:0] msk,
                              input logic [63:0] dat, input logic cor);
    exp_t e;
    int   idx;
    logic legal;
    logic inr;
    idx   = int'(addr[10:3]);
    legal = (op == 3'd0 || op == 3'd1 || op == 3'd4) && (sz <= 4'd3);
    inr   = addr_in_range(addr);
    e.size = sz;
    e.source = src;
    e.opcode = 3'd0;
    e.denied = 1'b0;
    e.corrupt = 1'b0;
    e.data = 64'd0;
    if (!legal) begin
      e.denied = 1'b1;
    end else if (op == 3'd4) begin
      e.opcode = 3'd1;
      if (inr) e.data = m_mem[idx];
      else begin
        e.denied = 1'b1;
        e.corrupt = 1'b1;
      end
    end else begin
      if (!inr) e.denied = 1'b1;
      else if (!cor) begin
        for (int b = 0; b < 8; b++)
          if (msk[b]) m_mem[idx][b*8 +: 8] = dat[b*8 +: 8];
      end
    end
    exp_q.push_back(e);
  endtask

  // One clock: drive inputs, check D and handshake at the falling edge, update the model.
  task automatic step(input logic v, input logic [2:0] op, input logic [3:0] sz, input logic [7:0] src,
                      input logic [30:0] addr, input logic [7:0] msk, input logic [63:0] dat,
                      input logic cor, input logic drdy, input logic rst);
    reset = rst;
    io_a_valid = v;
    io_a_bits_opcode = op;
    io_a_bits_param = 3'($urandom_range(0, 7));
    io_a_bits_size = sz;
    io_a_bits_source = src;
    io_a_bits_address = addr;
    io_a_bits_mask = msk;
    io_a_bits_data = dat;
    io_a_bits_corrupt = cor;
    io_d_ready = drdy;
    @(negedge clock);
    if (rst) begin
      exp_q.delete();
    end else begin
      check_eq("d_valid", io_d_valid, exp_q.size() != 0);
      check_eq("a_ready", io_a_ready, (exp_q.size() == 0) || drdy);
      if (io_d_valid && exp_q.size() != 0) begin
        check_eq("d_opcode", io_d_bits_opcode, exp_q[0].opcode);
        check_eq("d_param", io_d_bits_param, 0);
        check_eq("d_size", io_d_bits_size, exp_q[0].size);
        check_eq("d_source", io_d_bits_source, exp_q[0].source);
        check_eq("d_denied", io_d_bits_denied, exp_q[0].denied);
        check_eq("d_corrupt", io_d_bits_corrupt, exp_q[0].corrupt);
        check_eq("d_data", io_d_bits_data, exp_q[0].data);
      end
      if (io_d_valid && drdy) begin
        last_op = io_d_bits_opcode;
        last_src = io_d_bits_source;
        last_den = io_d_bits_denied;
        last_cor = io_d_bits_corrupt;
        last_data = io_d_bits_data;
        dsrc_log.push_back(int'(io_d_bits_source));
        dcyc_log.push_back(step_no);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (v && io_a_ready) model_accept(op, sz, src, addr, msk, dat, cor);
    end
    step_no++;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input logic drdy);
    step(1'b0, 3'd0, 4'd0, 8'd0, 31'd0, 8'd0, 64'd0, 1'b0, drdy, 1'b0);
  endtask

  task automatic flush();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle(1'b1);
    check_eq("flush_drained", exp_q.size(), 0);
  endtask

  task automatic put(input logic [2:0] op, input logic [30:0] addr, input logic [7:0] msk,
                     input logic [63:0] dat, input logic [7:0] src);
    step(1'b1, op, 4'd3, src, addr, msk, dat, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic get(input logic [30:0] addr, input logic [3:0] sz, input logic [7:0] src, input logic drdy);
    step(1'b1, 3'd4, sz, src, addr, 8'hFF, 64'd0, 1'b0, drdy, 1'b0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [3:0]  sz;
    logic [30:0] addr;
    logic [2:0]  illegal_ops [5];
    illegal_ops = '{3'd2, 3'd3, 3'd5, 3'd6, 3'd7};

    reset = 1'b1;
    for (int i = 0; i < 3; i++)
      step(1'b0, 3'd0, 4'd0, 8'd0, 31'd0, 8'd0, 64'd0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    check_eq("rst_d_valid", io_d_valid, 0);
    check_eq("rst_a_ready", io_a_ready, 1);
    check_eq("rst_d_opcode", io_d_bits_opcode, 0);
    check_eq("rst_d_data", io_d_bits_data, 0);
    check_eq("rst_d_denied", io_d_bits_denied, 0);

    for (int i = 0; i < 256; i++)
      put(3'd0, BASE | 31'(i << 3), 8'hFF, {$urandom, $urandom}, 8'(i));
    flush();

    put(3'd0, 31'h0800_0010, 8'hFF, 64'h1122_3344_5566_7788, 8'd5);
    flush();
    check_eq("putfull_op", last_op, 0);
    check_eq("putfull_src", last_src, 5);
    check_eq("putfull_den", last_den, 0);
    get(31'h0800_0010, 4'd3, 8'd6, 1'b1);
    flush();
    check_eq("get_op", last_op, 1);
    check_eq("get_data", last_data, 64'h1122_3344_5566_7788);

    put(3'd1, 31'h0800_0010, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, 8'd7);
    get(31'h0800_0010, 4'd3, 8'd8, 1'b1);
    flush();
    check_eq("partial_data", last_data, 64'h1122_3344_BBBB_BBBB);

    dsrc_log.delete();
    dcyc_log.delete();
    get(31'h0800_0020, 4'd3, 8'd1, 1'b1);
    for (int i = 0; i < 4; i++) get(31'h0800_0028, 4'd3, 8'd2, 1'b0);
    get(31'h0800_0028, 4'd3, 8'd2, 1'b1);
    flush();
    check_eq("stall_count", dsrc_log.size(), 2);
    if (dsrc_log.size() == 2) begin
      check_eq("stall_src0", dsrc_log[0], 1);
      check_eq("stall_src1", dsrc_log[1], 2);
    end

    dsrc_log.delete();
    dcyc_log.delete();
    for (int i = 0; i < 8; i++) get(BASE | 31'(i << 3), 4'd3, 8'(i), 1'b1);
    flush();
    check_eq("stream_count", dsrc_log.size(), 8);
    if (dsrc_log.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check_eq("stream_src", dsrc_log[i], i);
        check_eq("stream_cycle", dcyc_log[i], dcyc_log[0] + i);
      end
    end

    put(3'd2, 31'h0800_0010, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 8'd9);
    flush();
    check_eq("arith_op", last_op, 0);
    check_eq("arith_den", last_den, 1);
    get(31'h0800_0010, 4'd4, 8'd10, 1'b1);
    flush();
    check_eq("size4_op", last_op, 0);
    check_eq("size4_den", last_den, 1);
    check_eq("size4_data", last_data, 0);
    get(31'h0800_0010, 4'd3, 8'd11, 1'b1);
    flush();
    check_eq("illegal_nowrite", last_data, 64'h1122_3344_BBBB_BBBB);

`ifdef TL_RAM_ADDR_CHECK_EN
    get(31'h0000_0010, 4'd3, 8'd12, 1'b1);
    flush();
    check_eq("oor_op", last_op, 1);
    check_eq("oor_den", last_den, 1);
    check_eq("oor_cor", last_cor, 1);
    check_eq("oor_data", last_data, 0);
`endif

    get(31'h0800_0030, 4'd3, 8'd13, 1'b0);
    idle(1'b0);
    step(1'b0, 3'd0, 4'd0, 8'd0, 31'd0, 8'd0, 64'd0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    check_eq("rst_inflight", io_d_valid, 0);

    for (int n = 0; n < 2000; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 3) op = 3'd0;
      else if (r < 5) op = 3'd1;
      else if (r < 9) op = 3'd4;
      else op = illegal_ops[$urandom_range(0, 4)];
      sz = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
`ifdef TL_RAM_ADDR_CHECK_EN
      addr = ($urandom_range(0, 3) == 0) ? 31'($urandom) : (BASE | 31'($urandom_range(0, 2047)));
`else
      addr = 31'($urandom);
`endif
      step($urandom_range(0, 3) != 0, op, sz, 8'($urandom), addr, 8'($urandom),
           {$urandom, $urandom}, $urandom_range(0, 7) == 0, $urandom_range(0, 9) < 7, 1'b0);
    end
    flush();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
